// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester memory arbiter that shares one memory port between an
// instruction-fetch requester and a data requester. One access is in flight at
// a time, sequenced IDLE -> ISSUE -> WAIT -> RESP. Data normally wins, but a
// fetch that has been passed over STARVE_LIMIT times in a row is granted next.
// A WAIT phase that runs TIMEOUT_CYCLES cycles without mem_ready ends with a
// fault response and zero read data.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   if_req, if_addr                 fetch request (held until if_ack)
//   if_ack, if_fault                fetch completion pulse / fault (valid with ack)
//   d_req, d_op, d_addr, d_wdata    data request (held until d_ack)
//   d_ack, d_fault                  data completion pulse / fault (valid with ack)
//   rdata                           read data of the last completed access
//   mem_valid                       one-cycle issue strobe to memory
//   mem_op, mem_addr, mem_wdata     latched command of the granted requester
//   mem_ready, mem_fault, mem_rdata memory completion, fault and read data
//   busy                            high whenever an access is in progress
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int STARVE_LIMIT   = 2,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_fault,
  input  logic              d_req,
  input  logic [2:0]        d_op,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_fault,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_valid,
  output logic [2:0]        mem_op,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_fault,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] FETCH_OP   = 3'b010;
  localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);
  // Count value seen in the last allowed WAIT cycle.
  localparam logic [3:0] WAIT_LAST  = 4'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] starve_cnt;
  logic [3:0] wait_cnt;
  logic       grant_d;   // owner of the access in flight: 1 = data, 0 = fetch
  logic       fault_q;

  logic any_req;
  logic pick_d;
  logic timeout;

  function automatic logic [1:0] starve_sat_inc(input logic [1:0] cnt);
    if (cnt >= STARVE_MAX) return STARVE_MAX;
    return cnt + 2'd1;
  endfunction

  always_comb begin
    any_req   = if_req | d_req;
    // Data wins unless fetch has already been passed over STARVE_LIMIT times.
    pick_d    = d_req & ~(if_req & (starve_cnt == STARVE_MAX));
    timeout   = (wait_cnt == WAIT_LAST);
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mem_ready || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      grant_d    <= 1'b0;
      fault_q    <= 1'b0;
      rdata      <= '0;
      mem_op     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (!if_req)     starve_cnt <= '0;
          else if (pick_d) starve_cnt <= starve_sat_inc(starve_cnt);
          else             starve_cnt <= '0;
          if (any_req) begin
            grant_d <= pick_d;
            if (pick_d) begin
              mem_op    <= d_op;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_op    <= FETCH_OP;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (mem_ready) begin
            rdata   <= mem_rdata;
            fault_q <= mem_fault;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
            if (timeout) begin
              rdata   <= '0;
              fault_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign if_ack    = (state == RESP) & ~grant_d;
  assign d_ack     = (state == RESP) &  grant_d;
  assign if_fault  = if_ack & fault_q;
  assign d_fault   = d_ack  & fault_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: transaction-level reference model of two
// requesters and a memory, with directed scenarios followed by random traffic.
module tb_mem_arbiter;
  localparam int TIMEOUT = 15;
  localparam int LIMIT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack, if_fault;
  logic        d_req = 1'b0;
  logic [2:0]  d_op = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack, d_fault;
  logic [31:0] rdata;
  logic        mem_valid;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_fault = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .STARVE_LIMIT(LIMIT), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_fault(if_fault),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_fault(d_fault), .rdata(rdata),
    .mem_valid(mem_valid), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_fault(mem_fault), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct { logic [2:0] op; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct { int w; logic fault; logic [31:0] data; } plan_t;

  txn_t  if_q[$];
  txn_t  d_q[$];
  plan_t mem_q[$];

  int checks = 0;
  int failures = 0;

  // Reference model state (transaction level, tracked in cycle numbers)
  int          cyc = 0;
  bit          act = 0;
  int          issue_cyc = -100;
  int          ack_cyc = -100;
  int          ready_cyc = -1;
  bit          g_data = 0;
  bit          exp_fault = 0;
  logic        plan_fault = 0;
  logic [31:0] plan_data = '0;
  logic [31:0] resp_rdata = '0;
  logic [31:0] exp_rdata = '0;
  logic [2:0]  exp_op = '0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  int          dstreak = 0;
  bit          if_pend = 0;
  bit          d_pend = 0;
  txn_t        if_cur;
  txn_t        d_cur;
  string       glog = "";

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: check outputs of this cycle, then drive inputs for it.
  task automatic step(input bit do_reset, input bit late_ready);
    bit in_resp;
    bit idle_now;
    bit in_wait;
    plan_t p;
    @(negedge clk);
    cyc++;
    in_resp  = act && (cyc == ack_cyc);
    idle_now = !act;
    if (in_resp) exp_rdata = resp_rdata;

    check_val("mem_valid", 32'(mem_valid), 32'(act && cyc == issue_cyc));
    check_val("busy",      32'(busy),      32'(act && cyc >= issue_cyc && cyc <= ack_cyc));
    check_val("if_ack",    32'(if_ack),    32'(in_resp && !g_data));
    check_val("d_ack",     32'(d_ack),     32'(in_resp && g_data));
    check_val("if_fault",  32'(if_fault),  32'(in_resp && !g_data && exp_fault));
    check_val("d_fault",   32'(d_fault),   32'(in_resp && g_data && exp_fault));
    check_val("rdata",     rdata,          exp_rdata);
    check_val("mem_op",    32'(mem_op),    32'(exp_op));
    check_val("mem_addr",  mem_addr,       exp_addr);
    check_val("mem_wdata", mem_wdata,      exp_wdata);
    if (act && cyc == issue_cyc) glog = {glog, (mem_op == 3'b010) ? "F" : "D"};

    if (in_resp) begin
      if (g_data) d_pend = 0;
      else        if_pend = 0;
      act = 0;
    end

    if (do_reset) begin
      reset = 1'b1;
      if_req = 1'b0; d_req = 1'b0;
      if_pend = 0; d_pend = 0;
      act = 0; dstreak = 0;
      exp_rdata = '0; exp_op = '0; exp_addr = '0; exp_wdata = '0;
      mem_ready = 1'b0;
      mem_fault = 1'($urandom);
      mem_rdata = $urandom;
      return;
    end

    reset = 1'b0;
    if (!if_pend && if_q.size() != 0) begin if_cur = if_q.pop_front(); if_pend = 1; end
    if (!d_pend && d_q.size() != 0)   begin d_cur = d_q.pop_front();   d_pend = 1; end
    if_req  = if_pend;
    if_addr = if_pend ? if_cur.addr : $urandom;
    d_req   = d_pend;
    d_op    = d_pend ? d_cur.op : 3'($urandom);
    d_addr  = d_pend ? d_cur.addr : $urandom;
    d_wdata = d_pend ? d_cur.wdata : $urandom;

    if (idle_now) begin
      if (!if_req) dstreak = 0;
      if (if_req || d_req) begin
        // Data goes first unless fetch was already passed over LIMIT times.
        g_data = d_req && !(if_req && dstreak == LIMIT);
        if (if_req) dstreak = g_data ? ((dstreak < LIMIT) ? dstreak + 1 : LIMIT) : 0;
        exp_op    = g_data ? d_op : 3'b010;
        exp_addr  = g_data ? d_addr : if_addr;
        exp_wdata = g_data ? d_wdata : 32'h0;
        act = 1;
        issue_cyc = cyc + 1;
        if (mem_q.size() != 0) p = mem_q.pop_front();
        else begin
          p.w     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 3));
          p.fault = ($urandom_range(0, 7) == 0);
          p.data  = $urandom;
        end
        plan_fault = p.fault;
        plan_data  = p.data;
        if (p.w < TIMEOUT) begin
          ready_cyc  = cyc + 2 + p.w;
          ack_cyc    = ready_cyc + 1;
          exp_fault  = p.fault;
          resp_rdata = p.data;
        end else begin
          ready_cyc  = -1;
          ack_cyc    = cyc + 2 + TIMEOUT;
          exp_fault  = 1;
          resp_rdata = '0;
        end
      end
    end

    in_wait = act && cyc > issue_cyc && cyc < ack_cyc;
    if (act && cyc == ready_cyc) begin
      mem_ready = 1'b1; mem_fault = plan_fault; mem_rdata = plan_data;
    end else if (!in_wait) begin
      // Outside WAIT a stray mem_ready must have no effect.
      mem_ready = late_ready | ($urandom_range(0, 3) == 0);
      mem_fault = 1'($urandom);
      mem_rdata = $urandom;
    end else begin
      mem_ready = 1'b0;
      mem_fault = 1'($urandom);
      mem_rdata = $urandom;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((act || if_pend || d_pend || if_q.size() != 0 || d_q.size() != 0) && n < budget) begin
      step(0, 0);
      n++;
    end
    check_val(tag, 32'(n < budget), 32'd1);
  endtask

  function automatic txn_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
    txn_t t;
    t.op = op; t.addr = a; t.wdata = w;
    return t;
  endfunction

  function automatic plan_t mp(input int w, input logic f, input logic [31:0] d);
    plan_t p;
    p.w = w; p.fault = f; p.data = d;
    return p;
  endfunction

  initial begin
    int n;
    // Reset state
    repeat (3) step(1, 0);
    step(0, 0);

    // Fetch only, minimum latency
    glog = "";
    if_q.push_back(mk(3'b000, 32'h100, 32'h0));
    mem_q.push_back(mp(0, 1'b0, 32'h0000_0013));
    drain("fetch_drain", 40);
    check_val("fetch_rdata", rdata, 32'h13);
    check_val("fetch_addr", mem_addr, 32'h100);
    check_val("fetch_op", 32'(mem_op), 32'h2);
    check_val("fetch_order", 32'(glog == "F"), 32'd1);

    // Simultaneous requests: data first, then fetch
    glog = "";
    if_q.push_back(mk(3'b000, 32'h300, 32'h0));
    d_q.push_back(mk(3'b110, 32'h200, 32'hDEAD_BEEF));
    mem_q.push_back(mp(0, 1'b0, 32'h1111_0000));
    mem_q.push_back(mp(1, 1'b0, 32'h2222_0000));
    drain("simul_drain", 40);
    check_val("simul_order", 32'(glog == "DF"), 32'd1);

    // Starvation limit
    glog = "";
    for (int i = 0; i < 2; i++) if_q.push_back(mk(3'b000, 32'h400 + 32'(i * 4), 32'h0));
    for (int i = 0; i < 4; i++) d_q.push_back(mk(3'b001, 32'h800 + 32'(i * 4), 32'(i)));
    drain("starve_drain", 80);
    check_val("starve_order", 32'(glog == "DDFDDF"), 32'd1);

    // Timeout, then a normal access
    d_q.push_back(mk(3'b001, 32'h500, 32'h0));
    mem_q.push_back(mp(99, 1'b0, 32'h0));
    drain("tmo_drain", 40);
    check_val("tmo_rdata", rdata, 32'h0);
    d_q.push_back(mk(3'b001, 32'h504, 32'h0));
    mem_q.push_back(mp(1, 1'b0, 32'h0000_CAFE));
    drain("after_tmo_drain", 40);
    check_val("after_tmo_rdata", rdata, 32'h0000_CAFE);

    // Memory fault on fetch
    if_q.push_back(mk(3'b000, 32'h600, 32'h0));
    mem_q.push_back(mp(2, 1'b1, 32'h5555_AAAA));
    drain("mfault_drain", 40);
    check_val("mfault_rdata", rdata, 32'h5555_AAAA);

    // Reset in WAIT, late mem_ready afterwards
    d_q.push_back(mk(3'b110, 32'h700, 32'h1234_5678));
    mem_q.push_back(mp(99, 1'b0, 32'h0));
    n = 0;
    while (!(act && cyc >= issue_cyc + 2) && n < 50) begin step(0, 0); n++; end
    check_val("reach_wait", 32'(n < 50), 32'd1);
    step(1, 0);
    step(0, 1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rdata", rdata, 32'h0);
    repeat (20) step(0, 0);

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      if (if_q.size() == 0 && $urandom_range(0, 2) == 0)
        if_q.push_back(mk(3'b000, $urandom, 32'h0));
      if (d_q.size() == 0 && $urandom_range(0, 2) == 0)
        d_q.push_back(mk(3'($urandom), $urandom, $urandom));
      step($urandom_range(0, 299) == 0, 1'b0);
    end
    drain("final_drain", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, max WAIT-state cycles before a forced fault response (range 1..15).
REQ-002 Parameter STARVE_LIMIT, default 2, max consecutive data grants while fetch is pending (range 1..3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  fetch request; held with if_addr until if_ack.
REQ-006 if_addr  input  32  fetch address.
REQ-007 if_ack / if_fault  output  1 each  fetch completion pulse / fetch fault, valid with if_ack.
REQ-008 d_req  input  1  data request; held with d_op, d_addr, d_wdata until d_ack.
REQ-009 d_op / d_addr / d_wdata  input  3 / 32 / 32  data memory op, address, store data.
REQ-010 d_ack / d_fault  output  1 each  data completion pulse / data fault, valid with d_ack.
REQ-011 rdata  output  32  registered read data of the last completed access.
REQ-012 mem_valid  output  1  one-cycle issue strobe to memory.
REQ-013 mem_op / mem_addr / mem_wdata  output  3 / 32 / 32  latched op, address, store data of the granted request.
REQ-014 mem_ready / mem_fault / mem_rdata  input  1 / 1 / 32  memory completion, fault and read data.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; IDLE->ISSUE when any req high; ISSUE->WAIT unconditionally; WAIT->RESP on mem_ready or timeout; RESP->IDLE unconditionally.
REQ-017 In IDLE, grant goes to data when d_req, else to fetch; exception: if_req high and starve count == STARVE_LIMIT grants fetch.
REQ-018 Starve count (2 bits) increments on each data grant while if_req high, clears on fetch grant or when if_req is low in IDLE, saturates at STARVE_LIMIT.
REQ-019 On grant, op/addr/wdata are latched; fetch issues mem_op=3'b010, mem_wdata=0; data issues d_op/d_addr/d_wdata unchanged.
REQ-020 mem_valid is high exactly during ISSUE; mem_op/mem_addr/mem_wdata hold latched values from ISSUE through RESP.
REQ-021 mem_ready is sampled only in WAIT; mem_ready in any other state is ignored.
REQ-022 WAIT cycle counter (4 bits) clears on ISSUE, increments each WAIT cycle without mem_ready; reaching TIMEOUT_CYCLES forces RESP with fault=1 and rdata=0.
REQ-023 On mem_ready in WAIT: rdata <= mem_rdata, fault <= mem_fault, both registered on the WAIT->RESP edge.
REQ-024 In RESP, exactly one of if_ack/d_ack is high for one cycle (the granted requester); its fault output equals the latched fault; the non-granted fault output is 0.
REQ-025 Minimum latency: req sampled in IDLE at cycle n, mem_valid at n+1, mem_ready at n+2 gives ack at n+3.
REQ-026 A req still high in the IDLE cycle after ack is treated as a new request.
REQ-027 rdata holds its value outside the WAIT->RESP update, including across write accesses (write response rdata = mem_rdata as delivered).
REQ-028 if_fault/d_fault are 0 whenever their ack is 0.

Reset
REQ-029 On reset: state=IDLE; mem_valid, if_ack, d_ack, if_fault, d_fault, busy = 0; rdata, mem_op, mem_addr, mem_wdata = 0; starve and wait counters = 0.
REQ-030 Reset asserted in ISSUE/WAIT/RESP aborts the access: no ack is produced, and a late mem_ready after reset is ignored.
REQ-031 Reset has priority over all other events in the same cycle.

Verification
REQ-032 Fetch only: if_req, if_addr=0x100; mem_ready+mem_rdata=0x00000013 one cycle after mem_valid -> mem_op=3'b010, mem_addr=0x100, if_ack at cycle n+3, rdata=0x13, if_fault=0.
REQ-033 Simultaneous if_req and d_req (d_addr=0x200, d_op=3'b110, d_wdata=0xDEADBEEF) -> data granted first, mem_wdata=0xDEADBEEF, d_ack; fetch then granted, if_ack.
REQ-034 Starvation: d_req held high continuously with if_req pending, STARVE_LIMIT=2 -> grant order D, D, F, D, D, F.
REQ-035 Timeout: d_req, mem_ready never asserted -> d_ack after 15 WAIT cycles with d_fault=1, rdata=0; next access completes normally.
REQ-036 Memory fault: mem_ready with mem_fault=1 on fetch -> if_ack with if_fault=1, d_fault=0.
REQ-037 Reset in WAIT with mem_ready the next cycle -> no ack, busy=0, all outputs at reset values.
